// File: rtl/xbus_pkg.sv
// xbus_pkg: shared FSM state encoding and the reserved broadcast tag value.
`default_nettype none

package xbus_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CFG   = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } xbus_state_t;

  // Wide all-ones pattern; users slice it down to their tag width.
  localparam logic [31:0] BCAST_TAG = '1;

endpackage

`default_nettype wire

// File: rtl/xbus_tag_gen.sv
// xbus_tag_gen: walks one column per cycle while walk is high, assigning group
// tags and lock bits; flags cfg_err when the walk leaves every column locked.
`default_nettype none

module xbus_tag_gen
  import xbus_pkg::*;
#(
  parameter int NUM_COL = 8,
  parameter int TAG_W   = $clog2(NUM_COL) + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     walk,
  input  logic                     clr_err,
  input  logic [7:0]               ks,
  input  logic [TAG_W-1:0]         na,
  output logic [NUM_COL*TAG_W-1:0] col_tag,
  output logic [NUM_COL-1:0]       col_lock,
  output logic                     cfg_err,
  output logic                     last
);

  localparam int IDX_W = $clog2(NUM_COL);
  localparam int ACC_W = 16;

  logic [IDX_W-1:0] idx;
  logic [7:0]       k;
  logic [TAG_W-1:0] g;
  logic [ACC_W-1:0] base;
  logic             any_open;

  logic [ACC_W-1:0] base_end;
  logic [ACC_W-1:0] na_ext;
  logic [ACC_W-1:0] idx_ext;
  logic             lock_now;
  logic             wrap;

  // base tracks g*ks incrementally so the group end needs no multiplier.
  assign base_end = base + ACC_W'(ks);
  assign na_ext   = ACC_W'(na);
  assign idx_ext  = ACC_W'(idx);
  assign lock_now = (idx_ext >= na_ext) || (base_end > na_ext);
  assign wrap     = (k == ks - 8'd1);
  assign last     = walk && (idx == IDX_W'(NUM_COL - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      idx      <= '0;
      k        <= '0;
      g        <= '0;
      base     <= '0;
      any_open <= 1'b0;
      col_tag  <= '0;
      col_lock <= '1;
      cfg_err  <= 1'b0;
    end else begin
      if (clr_err) begin
        cfg_err <= 1'b0;
      end
      if (walk) begin
        col_tag[int'(idx)*TAG_W +: TAG_W] <= g;
        col_lock[idx]                     <= lock_now;
        idx                               <= idx + IDX_W'(1);
        if (wrap) begin
          k    <= '0;
          g    <= g + TAG_W'(1);
          base <= base_end;
        end else begin
          k <= k + 8'd1;
        end
        if (!lock_now) begin
          any_open <= 1'b1;
        end
        if (last) begin
          cfg_err <= !any_open && lock_now;
        end
      end else begin
        idx      <= '0;
        k        <= '0;
        g        <= '0;
        base     <= '0;
        any_open <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/xbus_mcast_ctrl.sv
// xbus_mcast_ctrl: tag-programmed multicast from one input stream to NUM_COL PE
// columns. Optional XBUS_DROP_CNT_EN adds drop_cnt/drop_flag outputs.
`default_nettype none

module xbus_mcast_ctrl
  import xbus_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_COL    = 8,
  parameter int TAG_W      = $clog2(NUM_COL) + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_start,
  input  logic [7:0]               kernel_size,
  input  logic [TAG_W-1:0]         num_active,
  output logic                     busy,
  output logic                     cfg_done,
  output logic                     cfg_err,
  output logic [NUM_COL*TAG_W-1:0] col_tag,
  output logic [NUM_COL-1:0]       col_lock,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [TAG_W-1:0]         in_tag,
  input  logic [DATA_WIDTH-1:0]    in_data,
  output logic [DATA_WIDTH-1:0]    pe_data,
  output logic [NUM_COL-1:0]       pe_valid,
  input  logic [NUM_COL-1:0]       pe_ready
`ifdef XBUS_DROP_CNT_EN
  ,
  output logic [15:0]              drop_cnt,
  output logic                     drop_flag
`endif
);

  localparam logic [TAG_W-1:0] BCAST   = BCAST_TAG[TAG_W-1:0];
  localparam logic [TAG_W-1:0] COL_CNT = TAG_W'(NUM_COL);

  xbus_state_t        state, state_nxt;
  logic [7:0]         ks_q;
  logic [TAG_W-1:0]   na_q;
  logic [NUM_COL-1:0] pend, pend_nxt, match;
  logic               cfg_accept;
  logic               accept;
  logic               walk_last;

  assign cfg_accept = cfg_start && ((state == IDLE) || (state == RUN));
  assign in_ready   = (state == RUN) && ((pend & ~pe_ready) == '0);
  assign accept     = in_valid && in_ready;
  assign busy       = (state == CFG) || (state == DRAIN);
  assign pe_valid   = pend;

  for (genvar i = 0; i < NUM_COL; i++) begin : g_match
    assign match[i] = !col_lock[i] &&
                      ((in_tag == col_tag[i*TAG_W +: TAG_W]) || (in_tag == BCAST));
  end

  xbus_tag_gen #(
    .NUM_COL (NUM_COL),
    .TAG_W   (TAG_W)
  ) u_tag_gen (
    .clk      (clk),
    .rst      (rst),
    .walk     (state == CFG),
    .clr_err  (cfg_accept),
    .ks       (ks_q),
    .na       (na_q),
    .col_tag  (col_tag),
    .col_lock (col_lock),
    .cfg_err  (cfg_err),
    .last     (walk_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    pend_nxt  = accept ? match : (pend & ~pe_ready);
    state_nxt = state;
    case (state)
      IDLE:    if (cfg_start) state_nxt = CFG;
      CFG:     if (walk_last) state_nxt = RUN;
      // A word accepted alongside cfg_start must drain before tags change.
      RUN:     if (cfg_start) state_nxt = (pend_nxt != '0) ? DRAIN : CFG;
      DRAIN:   if (pend_nxt == '0) state_nxt = CFG;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ks_q     <= 8'd1;
      na_q     <= '0;
      pend     <= '0;
      pe_data  <= '0;
      cfg_done <= 1'b0;
    end else begin
      pend     <= pend_nxt;
      cfg_done <= walk_last;
      if (accept) begin
        pe_data <= in_data;
      end
      if (cfg_accept) begin
        ks_q <= (kernel_size == 8'd0) ? 8'd1 : kernel_size;
        na_q <= (num_active > COL_CNT) ? COL_CNT : num_active;
      end
    end
  end

`ifdef XBUS_DROP_CNT_EN
  always_ff @(posedge clk) begin
    if (rst || cfg_accept) begin
      drop_cnt  <= '0;
      drop_flag <= 1'b0;
    end else if (accept && (match == '0)) begin
      drop_flag <= 1'b1;
      if (drop_cnt != 16'hFFFF) begin
        drop_cnt <= drop_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_xbus_mcast_ctrl.sv
// tb_xbus_mcast_ctrl: scoreboard bench; expected multicast masks come from a
// division-based reference of the tag table.
`default_nettype none

module tb_xbus_mcast_ctrl;

  localparam int DW = 16;
  localparam int NC = 8;
  localparam int TW = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           cfg_start = 1'b0;
  logic [7:0]     kernel_size = 8'd0;
  logic [TW-1:0]  num_active = '0;
  logic           busy, cfg_done, cfg_err;
  logic [NC*TW-1:0] col_tag;
  logic [NC-1:0]  col_lock;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [TW-1:0]  in_tag = '0;
  logic [DW-1:0]  in_data = '0;
  logic [DW-1:0]  pe_data;
  logic [NC-1:0]  pe_valid;
  logic [NC-1:0]  pe_ready = '1;
`ifdef XBUS_DROP_CNT_EN
  logic [15:0]    drop_cnt;
  logic           drop_flag;
`endif

  always #5 clk = ~clk;

  xbus_mcast_ctrl #(.DATA_WIDTH(DW), .NUM_COL(NC), .TAG_W(TW)) dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .kernel_size(kernel_size),
    .num_active(num_active), .busy(busy), .cfg_done(cfg_done), .cfg_err(cfg_err),
    .col_tag(col_tag), .col_lock(col_lock), .in_valid(in_valid), .in_ready(in_ready),
    .in_tag(in_tag), .in_data(in_data), .pe_data(pe_data), .pe_valid(pe_valid),
    .pe_ready(pe_ready)
`ifdef XBUS_DROP_CNT_EN
    , .drop_cnt(drop_cnt), .drop_flag(drop_flag)
`endif
  );

  typedef struct packed {
    logic [NC-1:0] mask;
    logic [DW-1:0] data;
  } exp_t;

  exp_t         sb[$];
  int           checks = 0;
  int           errors = 0;
  logic         acc_pending = 1'b0;
  logic [NC*TW-1:0] exp_tag = '0;
  logic [NC-1:0]    exp_lock = '1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_cfg(input int ks, input int na);
    int kse, nae, grp;
    kse = (ks == 0) ? 1 : ks;
    nae = (na > NC) ? NC : na;
    for (int i = 0; i < NC; i++) begin
      grp = i / kse;
      exp_tag[i*TW +: TW] = grp[TW-1:0];
      exp_lock[i] = (i >= nae) || (grp * kse + kse > nae);
    end
  endtask

  function automatic logic [NC-1:0] exp_mask(input logic [TW-1:0] tag);
    logic [NC-1:0] m;
    for (int i = 0; i < NC; i++)
      m[i] = !exp_lock[i] && ((exp_tag[i*TW +: TW] == tag) || (tag == '1));
    return m;
  endfunction

  // Each accept is checked against the oldest pushed expectation one cycle later.
  always @(negedge clk) begin
    exp_t e;
    if (acc_pending) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 64'(pe_valid), 64'(0));
      end else begin
        e = sb.pop_front();
        check("pe_valid", 64'(pe_valid), 64'(e.mask));
        if (e.mask != '0) check("pe_data", 64'(pe_data), 64'(e.data));
      end
    end
    acc_pending = !rst && in_valid && in_ready;
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [TW-1:0] tag, input logic [DW-1:0] data, output int waits);
    exp_t e;
    e.mask = exp_mask(tag);
    e.data = data;
    sb.push_back(e);
    in_valid = 1'b1;
    in_tag   = tag;
    in_data  = data;
    waits    = 0;
    @(negedge clk);
    while (!in_ready && waits < 50) begin
      waits++;
      @(negedge clk);
    end
    if (!in_ready) check("accept_timeout", 64'(in_ready), 64'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (!cfg_done && cyc < 40);
    if (!cfg_done) check("cfg_done_timeout", 64'(cfg_done), 64'(1));
  endtask

  task automatic check_cfg(input string tag);
    check({tag, "_tag"},  64'(col_tag),  64'(exp_tag));
    check({tag, "_lock"}, 64'(col_lock), 64'(exp_lock));
    check({tag, "_err"},  64'(cfg_err),  64'(exp_lock == '1));
  endtask

  task automatic configure(input int ks, input int na);
    int cyc;
    cfg_start   = 1'b1;
    kernel_size = 8'(ks);
    num_active  = TW'(na);
    @(posedge clk); #1;
    cfg_start = 1'b0;
    check("busy_in_cfg", 64'(busy), 64'(1));
    check("cfg_err_clr", 64'(cfg_err), 64'(0));
    wait_done(cyc);
    check("cfg_latency", 64'(cyc), 64'(8));
    check("busy_run", 64'(busy), 64'(0));
    model_cfg(ks, na);
    check_cfg("cfg");
    @(posedge clk); #1;
    check("cfg_done_pulse", 64'(cfg_done), 64'(0));
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_busy"},  64'(busy),     64'(0));
    check({tag, "_done"},  64'(cfg_done), 64'(0));
    check({tag, "_err"},   64'(cfg_err),  64'(0));
    check({tag, "_tag"},   64'(col_tag),  64'(0));
    check({tag, "_lock"},  64'(col_lock), 64'(8'hFF));
    check({tag, "_valid"}, 64'(pe_valid), 64'(0));
    check({tag, "_data"},  64'(pe_data),  64'(0));
    check({tag, "_rdy"},   64'(in_ready), 64'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int w, cyc;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_reset_state("reset");

    // ks=3, 8 active: tags 0,0,0,1,1,1,2,2 with group 2 incomplete
    configure(3, 8);

    send(4'd1, 16'hBEEF, w);  check("b2b_0", 64'(w), 64'(0));
    send(4'd0, 16'h1234, w);  check("b2b_1", 64'(w), 64'(0));
    send(4'd1, 16'h4321, w);  check("b2b_2", 64'(w), 64'(0));

    // column 1 stalls for five cycles of a tag-0 word
    pe_ready = 8'hFD;
    send(4'd0, 16'hA5A5, w);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp_valid", 64'(pe_valid), (c == 0) ? 64'(8'h07) : 64'(8'h02));
      check("bp_rdy_low", 64'(in_ready), 64'(0));
      if (c == 4) begin
        pe_ready = '1;
        #1 check("bp_rdy_high", 64'(in_ready), 64'(1));
      end
    end
    @(negedge clk);
    check("bp_clear", 64'(pe_valid), 64'(0));
    @(posedge clk); #1;

    send(4'hF, 16'h5A5A, w);
    send(4'd5, 16'h0BAD, w);
    check("drop_rdy", 64'(in_ready), 64'(1));
`ifdef XBUS_DROP_CNT_EN
    check("drop_cnt", 64'(drop_cnt), 64'(1));
    check("drop_flag", 64'(drop_flag), 64'(1));
`endif

    // reconfigure in the same cycle a word is accepted, col3 stalled
    pe_ready    = 8'hF7;
    cfg_start   = 1'b1;
    kernel_size = 8'd0;
    num_active  = 4'd15;
    send(4'd1, 16'hC0DE, w);
    cfg_start = 1'b0;
    check("rc_accept", 64'(w), 64'(0));
    @(negedge clk);
    check("drain_busy", 64'(busy), 64'(1));
    check("drain_rdy", 64'(in_ready), 64'(0));
    repeat (2) begin
      @(negedge clk);
      check("drain_hold", 64'(pe_valid), 64'(8'h08));
      check("drain_busy2", 64'(busy), 64'(1));
    end
    pe_ready = '1;
    @(negedge clk);
    check("drain_done", 64'(pe_valid), 64'(0));
    check("cfg_busy", 64'(busy), 64'(1));
    @(posedge clk); #1;
    wait_done(cyc);
    model_cfg(0, 15);
    check_cfg("rc");
`ifdef XBUS_DROP_CNT_EN
    check("drop_cnt_clr", 64'(drop_cnt), 64'(0));
`endif
    @(posedge clk); #1;
    send(4'd6, 16'h6666, w);

    // reset in the middle of a configuration walk
    cfg_start   = 1'b1;
    kernel_size = 8'd2;
    num_active  = 4'd5;
    @(posedge clk); #1;
    cfg_start = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_cfg(1, 0);
    check_reset_state("midrst");

    // kernel larger than the active set: everything locked
    configure(9, 8);
    send(4'd0, 16'h0F0F, w);

    configure(2, 5);
    send(4'hF, 16'h7777, w);
    send(4'd2, 16'h8888, w);

    repeat (2) @(negedge clk);
    check("sb_drain", 64'(sb.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
